// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared encodings for the writeback stage: result selects, RV32I load funct3 codes,
// FSM state encodings and the latched pending-load record.
package reg_writeback_ctrl_pkg;

    localparam logic [1:0] WB_X   = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;
    localparam logic [1:0] WB_PC  = 2'd3;

    localparam logic [2:0] LD_B  = 3'd0;
    localparam logic [2:0] LD_H  = 3'd1;
    localparam logic [2:0] LD_W  = 3'd2;
    localparam logic [2:0] LD_BU = 3'd4;
    localparam logic [2:0] LD_HU = 3'd5;

    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] S_IDLE     = 1'b0;
    localparam logic [STATE_W-1:0] S_WAIT_MEM = 1'b1;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] off;
    } pend_load_t;

endpackage

// File: rtl/reg_writeback_ctrl_load_align.sv
// Combinational load aligner: picks the byte/half/word addressed by off out of the
// memory word and sign- or zero-extends it according to the RV32I load funct3.
module wb_load_align
    import reg_writeback_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    output logic [31:0] value
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // off[0] is deliberately ignored for halfword loads
    assign byte_v = rdata[{off, 3'b000} +: 8];
    assign half_v = rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        value = 32'd0;
        case (funct3)
            LD_B:    value = {{24{byte_v[7]}}, byte_v};
            LD_H:    value = {{16{half_v[15]}}, half_v};
            LD_W:    value = rdata;
            LD_BU:   value = {24'd0, byte_v};
            LD_HU:   value = {16'd0, half_v};
            default: value = 32'd0;
        endcase
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Writeback stage driving the register-file write port; loads wait for mem_rvalid
// under a timeout. Define WB_BYPASS_EN to add the fwd_* decode-bypass outputs.
module reg_writeback_ctrl
    import reg_writeback_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic               clk,
    input  logic               reset,
    // Handshake: an instruction is accepted on a cycle where in_valid and in_ready
    // are both high; in_ready depends only on state, never on in_valid.
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         rd_addr,
    input  logic [1:0]         wb_sel,
    input  logic [2:0]         ld_funct3,
    input  logic [31:0]        alu_out,
    input  logic [31:0]        pc,
    input  logic [31:0]        mem_rdata,
    input  logic               mem_rvalid,
    output logic               write_en,
    output logic [4:0]         write_addr,
    output logic [31:0]        write_value,
    output logic               err,
    output logic [STATE_W-1:0] dbg_state
`ifdef WB_BYPASS_EN
    ,
    output logic               fwd_valid,
    output logic [4:0]         fwd_addr,
    output logic [31:0]        fwd_data
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    pend_load_t         pend_q, pend_d;
    logic               write_en_q, write_en_d;
    logic [4:0]         write_addr_q, write_addr_d;
    logic [31:0]        write_value_q, write_value_d;
    logic               err_q, err_d;
    logic [31:0]        ld_value;
    logic               accept;

    wb_load_align u_align (
        .rdata  (mem_rdata),
        .funct3 (pend_q.funct3),
        .off    (pend_q.off),
        .value  (ld_value)
    );

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_d        = pend_q;
        write_en_d    = 1'b0;
        write_addr_d  = write_addr_q;
        write_value_d = write_value_q;
        err_d         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (wb_sel)
                        WB_ALU: begin
                            write_addr_d  = rd_addr;
                            write_value_d = alu_out;
                            write_en_d    = (rd_addr != 5'd0);
                        end
                        WB_PC: begin
                            write_addr_d  = rd_addr;
                            write_value_d = pc + 32'd4;
                            write_en_d    = (rd_addr != 5'd0);
                        end
                        WB_MEM: begin
                            pend_d.rd     = rd_addr;
                            pend_d.funct3 = ld_funct3;
                            pend_d.off    = alu_out[1:0];
                            cnt_d         = '0;
                            state_d       = S_WAIT_MEM;
                        end
                        default: ;
                    endcase
                end
            end
            S_WAIT_MEM: begin
                // A response arriving on the final wait cycle beats the timeout
                if (mem_rvalid) begin
                    write_addr_d  = pend_q.rd;
                    write_value_d = ld_value;
                    write_en_d    = (pend_q.rd != 5'd0);
                    state_d       = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            pend_q        <= '0;
            write_en_q    <= 1'b0;
            write_addr_q  <= 5'd0;
            write_value_q <= 32'd0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            write_en_q    <= write_en_d;
            write_addr_q  <= write_addr_d;
            write_value_q <= write_value_d;
            err_q         <= err_d;
        end
    end

    assign write_en    = write_en_q;
    assign write_addr  = write_addr_q;
    assign write_value = write_value_q;
    assign err         = err_q;
    assign dbg_state   = state_q;

`ifdef WB_BYPASS_EN
    assign fwd_valid = write_en_q & (write_addr_q != 5'd0);
    assign fwd_addr  = write_addr_q;
    assign fwd_data  = write_value_q;
`endif

endmodule
